sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
// Shares the single Avalon-MM SDRAM port (HPS FPGA-to-SDRAM bridge) between the display read
// path and the frame write path. The reader has priority; a starvation limit guarantees writer
// progress. The block locks the grant for whole write bursts, tracks outstanding read beats and
// throttles new reads above a ceiling. It sits between the SDRAM bridge and both masters.
// PARAMETERS
// DATA_WIDTH      64   SDRAM data width, bits
// ADDR_WIDTH      27   Avalon word address width
// BURST_WIDTH     8    burstcount width
// STARVE_LIMIT    16   max consecutive accepted read commands while writer waits
// MAX_OUTSTANDING 255  max read beats issued but not yet returned
// PORTS
// sdram_clk        in   1            clock; every port is synchronous to it
// rst              in   1            sync active-high reset
// rd_address_i     in   ADDR_WIDTH   reader word address
// rd_burstcount_i  in   BURST_WIDTH  reader burst length, 1..255
// rd_read_i        in   1            reader read command
// rd_waitrequest_o out  1            stall to reader
// rd_readdata_o    out  DATA_WIDTH   returned data (mem_readdata_i passthrough)
// rd_readdatavalid_o out 1           returned data valid (mem_readdatavalid_i passthrough)
// wr_address_i     in   ADDR_WIDTH   writer burst start address
// wr_burstcount_i  in   BURST_WIDTH  writer burst length, 1..255; sampled on the first beat
// wr_write_i       in   1            writer write beat
// wr_writedata_i   in   DATA_WIDTH   writer data
// wr_byteenable_i  in   DATA_WIDTH/8 writer byte enables
// wr_waitrequest_o out  1            stall to writer
// mem_address_o    out  ADDR_WIDTH   muxed address to SDRAM
// mem_burstcount_o out  BURST_WIDTH  muxed burstcount
// mem_read_o       out  1            read to SDRAM
// mem_write_o      out  1            write to SDRAM
// mem_writedata_o  out  DATA_WIDTH   write data
// mem_byteenable_o out  DATA_WIDTH/8 byte enables
// mem_waitrequest_i in  1            SDRAM stall
// mem_readdata_i   in   DATA_WIDTH   SDRAM read data
// mem_readdatavalid_i in 1           SDRAM read data valid
// outstanding_o    out  9            read beats in flight (debug/status)
// BEHAVIOUR
// - Registered FSM {IDLE, RD, WR}; mem_* outputs combinational from state plus the granted master.
// - Reset: state=IDLE, outstanding=0, starve_cnt=0, beat_cnt=0. Result: mem_read_o=0,
//   mem_write_o=0, rd/wr_waitrequest_o=1, outstanding_o=0.
// - Ungranted master always sees waitrequest=1, so it holds its command (Avalon rule).
// - IDLE: if rd_read_i & room -> RD. Else if wr_write_i -> WR. Grant takes effect next cycle.
//   room = outstanding + rd_burstcount_i <= MAX_OUTSTANDING.
// - RD: mem_read_o = rd_read_i & room; rd_waitrequest_o = mem_waitrequest_i | ~room.
//   accept_rd = mem_read_o & ~mem_waitrequest_i.
//   Each accept_rd increments starve_cnt while wr_write_i is high; starve_cnt clears when wr_write_i is low.
//   Leave RD only on a cycle with no pending unaccepted read (rd_read_i low or accept_rd):
//   -> WR if wr_write_i & (starve_cnt+1 >= STARVE_LIMIT or rd_read_i low), else -> IDLE if rd_read_i low.
// - WR: mem_write_o = wr_write_i; wr_waitrequest_o = mem_waitrequest_i.
//   On the first accepted beat, beat_cnt = wr_burstcount_i-1; then decrement per accepted beat.
//   Leave on the last accepted beat (beat_cnt==0 after the first beat, or burstcount==1):
//   -> RD if rd_read_i & room, else IDLE. starve_cnt clears. The grant is never broken mid-burst.
// - outstanding: += rd_burstcount_i on accept_rd, -1 per mem_readdatavalid_i; both in one cycle
//   -> net sum. Readdatavalid with outstanding==0 is a protocol error: count saturates at 0.
// - Read data returns in order and is always routed to the reader, whichever grant is active.
// - Reset mid-burst: the FSM returns to IDLE immediately. In-flight readdata is still forwarded,
//   but outstanding is not rebuilt. The system resets the SDRAM bridge together with this block.
// TESTING
// - Reader only, rd_read_i held, burst=1, no wait -> IDLE->RD in 1 cycle, one accept per cycle.
// - Writer only, burst 8, mem_waitrequest_i high on beats 3-4 -> exactly 8 mem_write_o accepts
//   with data in order, then IDLE.
// - Both continuous, STARVE_LIMIT=16 -> 16 read accepts, then an 8-beat write burst, then RD; repeating.
// - Reads burst=1, readdatavalid withheld -> accepts stop at outstanding=255 and rd_waitrequest_o=1.
//   One return -> exactly one more read accepted.
// - rst asserted in WR after beat 3 of 8 -> next cycle mem_write_o=0, both waitrequests=1, state IDLE.
// - Writer mid-burst while reader asserts -> reader waits until the burst ends, then is granted the next cycle.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-MM SDRAM port between a priority reader and a bursting writer
// Ports: sdram_clk/rst (sync, active-high); rd_* reader slave; wr_* writer slave;
// mem_* master to the SDRAM bridge; outstanding_o = read beats issued but not yet returned.
module sdram_port_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 27,
  parameter int BURST_WIDTH     = 8,
  parameter int STARVE_LIMIT    = 16,
  parameter int MAX_OUTSTANDING = 255
) (
  input  logic                    sdram_clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   rd_address_i,
  input  logic [BURST_WIDTH-1:0]  rd_burstcount_i,
  input  logic                    rd_read_i,
  output logic                    rd_waitrequest_o,
  output logic [DATA_WIDTH-1:0]   rd_readdata_o,
  output logic                    rd_readdatavalid_o,
  input  logic [ADDR_WIDTH-1:0]   wr_address_i,
  input  logic [BURST_WIDTH-1:0]  wr_burstcount_i,
  input  logic                    wr_write_i,
  input  logic [DATA_WIDTH-1:0]   wr_writedata_i,
  input  logic [DATA_WIDTH/8-1:0] wr_byteenable_i,
  output logic                    wr_waitrequest_o,
  output logic [ADDR_WIDTH-1:0]   mem_address_o,
  output logic [BURST_WIDTH-1:0]  mem_burstcount_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic [DATA_WIDTH-1:0]   mem_writedata_o,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable_o,
  input  logic                    mem_waitrequest_i,
  input  logic [DATA_WIDTH-1:0]   mem_readdata_i,
  input  logic                    mem_readdatavalid_i,
  output logic [8:0]              outstanding_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state_q, state_d;
  logic [8:0] outstanding_q, outstanding_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BURST_WIDTH-1:0] beat_q, beat_d;
  logic first_q, first_d;
  logic room, accept_rd, accept_wr, last_wr;
  logic [9:0] rd_total, out_sum;
  always_comb begin
    rd_total = 10'(outstanding_q) + 10'(rd_burstcount_i);
    room = rd_total <= 10'(MAX_OUTSTANDING);
    mem_read_o = state_q == RD && rd_read_i && room;
    mem_write_o = state_q == WR && wr_write_i;
    rd_waitrequest_o = state_q != RD || mem_waitrequest_i || !room;
    wr_waitrequest_o = state_q != WR || mem_waitrequest_i;
    mem_address_o = state_q == WR ? wr_address_i : rd_address_i;
    mem_burstcount_o = state_q == WR ? wr_burstcount_i : rd_burstcount_i;
    mem_writedata_o = wr_writedata_i;
    mem_byteenable_o = wr_byteenable_i;
    rd_readdata_o = mem_readdata_i;
    rd_readdatavalid_o = mem_readdatavalid_i;
    outstanding_o = outstanding_q;
    accept_rd = mem_read_o && !mem_waitrequest_i;
    accept_wr = mem_write_o && !mem_waitrequest_i;
    // first_q marks that the next accepted beat opens a burst and carries its length
    last_wr = accept_wr && (first_q ? wr_burstcount_i == BURST_WIDTH'(1) : beat_q == BURST_WIDTH'(1));
    beat_d = accept_wr ? (first_q ? wr_burstcount_i : beat_q) - BURST_WIDTH'(1) : beat_q;
    first_d = state_q != WR || (first_q && !accept_wr);
    // a return with nothing in flight is a protocol error; clamp at zero instead of wrapping
    out_sum = 10'(outstanding_q) + (accept_rd ? 10'(rd_burstcount_i) : 10'd0);
    outstanding_d = 9'(mem_readdatavalid_i && out_sum != 10'd0 ? out_sum - 10'd1 : out_sum);
    starve_d = !wr_write_i ? '0 : accept_rd ? starve_q + SW'(1) : starve_q;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = rd_read_i && room ? RD : wr_write_i ? WR : IDLE;
      RD: if (!rd_read_i || accept_rd)
        state_d = wr_write_i && (int'(starve_q) + 1 >= STARVE_LIMIT || !rd_read_i) ? WR :
                  !rd_read_i ? IDLE : RD;
      WR: if (last_wr) begin
        state_d = rd_read_i && room ? RD : IDLE;
        starve_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      state_q <= IDLE;
      outstanding_q <= '0;
      starve_q <= '0;
      beat_q <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      outstanding_q <= outstanding_d;
      starve_q <= starve_d;
      beat_q <= beat_d;
      first_q <= first_d;
    end
  end
endmodule
